mem_req_ctrl: RTL and testbench

- Initiator-side controller for the packed-row `mem` block's request port.
- Accepts read/write commands from AOC4 solver logic over a valid/ready command channel and drives mem's `write_en` / `read_en` / address / data pins with the correct handshake.
- Collects read data on `ack` and returns it over a valid/ready response channel.
- Provides a 2-entry command buffer, a watchdog timeout and transaction counters.

---
 rtl/mem_req_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_mem_req_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_ctrl.sv
// Initiator-side request controller for the packed-row mem block: buffers commands,
// sequences mem write/read handshakes, returns read data and counts completed transactions.
module mem_req_ctrl #(
  parameter int BANK_ADDR_WIDTH = 8,
  parameter int COL_ADDR_WIDTH  = 6,
  parameter int TX_DATA_WIDTH   = 17,
  parameter int WR_GAP          = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [BANK_ADDR_WIDTH-1:0] cmd_row,
  input  logic [COL_ADDR_WIDTH-1:0]  cmd_col,
  input  logic [TX_DATA_WIDTH-1:0]   cmd_data,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [TX_DATA_WIDTH-1:0]   rsp_data,
  output logic                       rsp_err,
  output logic                       write_en,
  output logic                       read_en,
  output logic [BANK_ADDR_WIDTH-1:0] row_addr_in,
  output logic [COL_ADDR_WIDTH-1:0]  col_addr_in,
  output logic [TX_DATA_WIDTH-1:0]   partial_vec_in,
  input  logic [TX_DATA_WIDTH-1:0]   partial_vec_out,
  input  logic                       ack,
  input  logic                       busy,
  output logic                       idle,
  output logic [15:0]                rd_count,
  output logic [15:0]                wr_count
);

  localparam int GAP_W = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ISSUE,
    ST_WR_GAP,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_RSP
  } state_t;

  state_t                     r_state;
  state_t                     w_nextState;
  logic                       r_bufWrite [2];
  logic [BANK_ADDR_WIDTH-1:0] r_bufRow   [2];
  logic [COL_ADDR_WIDTH-1:0]  r_bufCol   [2];
  logic [TX_DATA_WIDTH-1:0]   r_bufData  [2];
  logic                       r_wrPtr;
  logic                       r_rdPtr;
  logic [1:0]                 r_count;
  logic [GAP_W-1:0]           r_gapCnt;
  logic [TO_W-1:0]            r_toCnt;
  logic [BANK_ADDR_WIDTH-1:0] r_rowAddr;
  logic [COL_ADDR_WIDTH-1:0]  r_colAddr;
  logic [TX_DATA_WIDTH-1:0]   r_vecIn;
  logic [TX_DATA_WIDTH-1:0]   r_rspData;
  logic                       r_rspErr;
  logic [15:0]                r_rdCount;
  logic [15:0]                r_wrCount;
  logic                       w_push;
  logic                       w_pop;
  logic                       w_gapDone;
  logic                       w_wrDone;
  logic                       w_capture;
  logic                       w_timeout;
  logic                       w_rspDone;

  assign w_push    = cmd_valid && cmd_ready;
  assign w_pop     = (r_state == ST_IDLE) && (r_count != 2'd0) && !busy;
  assign w_gapDone = (r_gapCnt == GAP_W'(WR_GAP - 1));
  assign w_wrDone  = (r_state == ST_WR_GAP) && w_gapDone && !busy;
  // An ack coinciding with the first read_en cycle is accepted as well.
  assign w_capture = ((r_state == ST_RD_ISSUE) || (r_state == ST_RD_WAIT)) && ack;
  assign w_timeout = (r_state == ST_RD_WAIT) && !ack && (r_toCnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign w_rspDone = (r_state == ST_RSP) && rsp_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wrPtr <= 1'b0;
      r_rdPtr <= 1'b0;
      r_count <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_bufWrite[i] <= 1'b0;
        r_bufRow[i]   <= '0;
        r_bufCol[i]   <= '0;
        r_bufData[i]  <= '0;
      end
    end else begin
      if (w_push) begin
        r_bufWrite[r_wrPtr] <= cmd_write;
        r_bufRow[r_wrPtr]   <= cmd_row;
        r_bufCol[r_wrPtr]   <= cmd_col;
        r_bufData[r_wrPtr]  <= cmd_data;
        r_wrPtr             <= ~r_wrPtr;
      end
      if (w_pop) begin
        r_rdPtr <= ~r_rdPtr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    write_en    = 1'b0;
    read_en     = 1'b0;
    rsp_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pop) begin
          w_nextState = r_bufWrite[r_rdPtr] ? ST_WR_ISSUE : ST_RD_ISSUE;
        end
      end
      ST_WR_ISSUE: begin
        write_en    = 1'b1;
        w_nextState = ST_WR_GAP;
      end
      ST_WR_GAP: begin
        if (w_wrDone) w_nextState = ST_IDLE;
      end
      ST_RD_ISSUE: begin
        read_en     = 1'b1;
        w_nextState = w_capture ? ST_RSP : ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        read_en = 1'b1;
        if (w_capture || w_timeout) w_nextState = ST_RSP;
      end
      ST_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Mem-side pins only move when a command is popped, so they stay put for the whole transaction.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rowAddr <= '0;
      r_colAddr <= '0;
      r_vecIn   <= '0;
      r_gapCnt  <= '0;
      r_toCnt   <= '0;
      r_rspData <= '0;
      r_rspErr  <= 1'b0;
      r_rdCount <= 16'd0;
      r_wrCount <= 16'd0;
    end else begin
      if (w_pop) begin
        r_rowAddr <= r_bufRow[r_rdPtr];
        r_colAddr <= r_bufCol[r_rdPtr];
        r_vecIn   <= r_bufWrite[r_rdPtr] ? r_bufData[r_rdPtr] : '0;
      end
      if (r_state == ST_WR_ISSUE) begin
        r_gapCnt <= '0;
      end else if ((r_state == ST_WR_GAP) && !w_gapDone) begin
        r_gapCnt <= r_gapCnt + GAP_W'(1);
      end
      if (r_state == ST_RD_ISSUE) begin
        r_toCnt <= '0;
      end else if (r_state == ST_RD_WAIT) begin
        r_toCnt <= r_toCnt + TO_W'(1);
      end
      if (w_capture) begin
        r_rspData <= partial_vec_out;
        r_rspErr  <= 1'b0;
      end else if (w_timeout) begin
        r_rspData <= '0;
        r_rspErr  <= 1'b1;
      end
      if (w_wrDone)  r_wrCount <= r_wrCount + 16'd1;
      if (w_rspDone) r_rdCount <= r_rdCount + 16'd1;
    end
  end

  assign cmd_ready      = (r_count != 2'd2);
  assign idle           = (r_count == 2'd0) && (r_state == ST_IDLE);
  assign rsp_data       = r_rspData;
  assign rsp_err        = r_rspErr;
  assign row_addr_in    = r_rowAddr;
  assign col_addr_in    = r_colAddr;
  assign partial_vec_in = r_vecIn;
  assign rd_count       = r_rdCount;
  assign wr_count       = r_wrCount;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl: a small mem model answers reads, and a
// monitor records request start cycles and pulse widths for the checks below.
module tb_mem_req_ctrl;

  localparam int BW      = 8;
  localparam int CW      = 6;
  localparam int DW      = 17;
  localparam int WR_GAP  = 4;
  localparam int TIMEOUT = 64;

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [BW-1:0] cmd_row = '0;
  logic [CW-1:0] cmd_col = '0;
  logic [DW-1:0] cmd_data = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          write_en;
  logic          read_en;
  logic [BW-1:0] row_addr_in;
  logic [CW-1:0] col_addr_in;
  logic [DW-1:0] partial_vec_in;
  logic [DW-1:0] partial_vec_out = '0;
  logic          ack = 1'b0;
  logic          busy = 1'b0;
  logic          idle;
  logic [15:0]   rd_count;
  logic [15:0]   wr_count;

  int errors = 0;
  int checks = 0;

  mem_req_ctrl #(
    .BANK_ADDR_WIDTH(BW), .COL_ADDR_WIDTH(CW), .TX_DATA_WIDTH(DW),
    .WR_GAP(WR_GAP), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .write_en(write_en), .read_en(read_en), .row_addr_in(row_addr_in),
    .col_addr_in(col_addr_in), .partial_vec_in(partial_vec_in),
    .partial_vec_out(partial_vec_out), .ack(ack), .busy(busy),
    .idle(idle), .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clock = ~clock;

  // Mem model: stores writes, acks reads ackLat negedges after read_en is seen; row 1 col 34 never acks.
  logic [DW-1:0] memModel [0:(1<<(BW+CW))-1];
  int ackLat = 2;
  int latCnt = 0;

  always @(negedge clock) begin
    if (!reset_n) begin
      ack = 1'b0;
      latCnt = 0;
    end else begin
      if (write_en) memModel[{row_addr_in, col_addr_in}] = partial_vec_in;
      if (ack) begin
        ack = 1'b0;
        latCnt = 0;
      end else if (read_en && !(row_addr_in == 8'd1 && col_addr_in == 6'd34)) begin
        if (latCnt >= ackLat) begin
          ack = 1'b1;
          partial_vec_out = memModel[{row_addr_in, col_addr_in}];
        end else begin
          latCnt++;
        end
      end else begin
        latCnt = 0;
      end
    end
  end

  // Monitor sampled just after each rising edge.
  int cyc = 0;
  int bothViol = 0;
  int ackViol = 0;
  int rspSeen = 0;
  int wrRise = 0;
  int rdRise = 0;
  int reqStarts[$];
  int wrWidths[$];
  int rdWidths[$];
  logic prevWe = 1'b0;
  logic prevRe = 1'b0;

  always @(posedge clock) begin
    #1;
    cyc++;
    if (write_en && read_en) bothViol++;
    if (ack && read_en) ackViol++;
    if (rsp_valid) rspSeen++;
    if (write_en && !prevWe) begin wrRise = cyc; reqStarts.push_back(cyc); end
    if (!write_en && prevWe) wrWidths.push_back(cyc - wrRise);
    if (read_en && !prevRe) begin rdRise = cyc; reqStarts.push_back(cyc); end
    if (!read_en && prevRe) rdWidths.push_back(cyc - rdRise);
    prevWe = write_en;
    prevRe = read_en;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [BW-1:0] row, input logic [CW-1:0] col,
                               input logic [DW-1:0] data);
    int n = 0;
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_row   = row;
    cmd_col   = col;
    cmd_data  = data;
    while (!cmd_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) checkOutput("cmd_accept", 0, 1);
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic waitRsp(input string tag, output logic [DW-1:0] data, output logic err);
    bit got = 1'b0;
    data = '0;
    err  = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(posedge clock);
      #1;
      if (rsp_valid) begin
        got  = 1'b1;
        data = rsp_data;
        err  = rsp_err;
      end
    end
    if (!got) checkOutput({tag, "_no_rsp"}, 0, 1);
  endtask

  task automatic waitIdle(input string tag);
    bit done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clock);
      if (idle) done = 1'b1;
    end
    if (!done) checkOutput({tag, "_idle_timeout"}, 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    logic [DW-1:0] d;
    logic          e;
    int            holdBad;
    int            nBefore;
    int            fallCyc;
    int            rspBase;

    memModel[0]  = 17'd1234;
    memModel[34] = 17'd4567;

    // Reset values
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    checkOutput("rst_idle", idle, 1);
    checkOutput("rst_write_en", write_en, 0);
    checkOutput("rst_read_en", read_en, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rd_count", rd_count, 0);
    checkOutput("rst_wr_count", wr_count, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Two reads of row 0, different columns
    $display("[TB] step 1: back-to-back reads");
    applyStimulus(1'b0, 8'd0, 6'd0, 17'd0);
    applyStimulus(1'b0, 8'd0, 6'd34, 17'd0);
    waitRsp("rd1", d, e);
    checkOutput("rd1_data", d, 1234);
    checkOutput("rd1_err", e, 0);
    waitRsp("rd2", d, e);
    checkOutput("rd2_data", d, 4567);
    checkOutput("rd2_err", e, 0);
    waitIdle("step1");
    checkOutput("step1_rd_count", rd_count, 2);
    checkOutput("step1_ack_readen", ackViol, 0);

    // Two writes then a read of the same location; read acked on its first cycle
    $display("[TB] step 2: writes with gap, read-back");
    @(negedge clock);
    reqStarts.delete();
    wrWidths.delete();
    ackLat = 0;
    applyStimulus(1'b1, 8'd4, 6'd0, 17'd1234);
    applyStimulus(1'b1, 8'd4, 6'd0, 17'd1232);
    applyStimulus(1'b0, 8'd4, 6'd0, 17'd0);
    waitRsp("rd3", d, e);
    checkOutput("rd3_data", d, 1232);
    checkOutput("rd3_err", e, 0);
    waitIdle("step2");
    @(negedge clock);
    checkOutput("wr_pulse_count", wrWidths.size(), 2);
    checkOutput("wr_pulse0_width", wrWidths[0], 1);
    checkOutput("wr_pulse1_width", wrWidths[1], 1);
    checkOutput("wr_gap_0_1", 32'((reqStarts[1] - reqStarts[0]) >= WR_GAP + 1), 1);
    checkOutput("wr_gap_1_2", 32'((reqStarts[2] - reqStarts[1]) >= WR_GAP + 1), 1);
    checkOutput("step2_wr_count", wr_count, 2);
    checkOutput("rd_vec_in_zero", partial_vec_in, 0);
    checkOutput("rd_row_addr", row_addr_in, 4);

    // Response back-pressure with the buffer full
    $display("[TB] step 3: response back-pressure");
    ackLat = 2;
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 8'd0, 6'd0, 17'd0);
    applyStimulus(1'b0, 8'd0, 6'd34, 17'd0);
    applyStimulus(1'b0, 8'd4, 6'd0, 17'd0);
    waitRsp("rd4", d, e);
    checkOutput("rd4_data", d, 1234);
    holdBad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      if (!rsp_valid || rsp_data !== 17'd1234 || rsp_err !== 1'b0) holdBad++;
      if (read_en || write_en) holdBad++;
    end
    checkOutput("hold_stable", holdBad, 0);
    checkOutput("hold_cmd_ready", cmd_ready, 0);
    @(negedge clock);
    rsp_ready = 1'b1;
    waitRsp("rd5", d, e);
    checkOutput("rd5_data", d, 4567);
    waitRsp("rd6", d, e);
    checkOutput("rd6_data", d, 1232);
    waitIdle("step3");
    checkOutput("step3_rd_count", rd_count, 6);

    // Read that is never acked times out; the next queued read still completes
    $display("[TB] step 4: read timeout");
    @(negedge clock);
    rdWidths.delete();
    applyStimulus(1'b0, 8'd1, 6'd34, 17'd0);
    applyStimulus(1'b0, 8'd0, 6'd34, 17'd0);
    waitRsp("rd_to", d, e);
    checkOutput("to_err", e, 1);
    checkOutput("to_data", d, 0);
    checkOutput("to_read_en", read_en, 0);
    waitRsp("rd7", d, e);
    checkOutput("rd7_data", d, 4567);
    checkOutput("rd7_err", e, 0);
    waitIdle("step4");
    @(negedge clock);
    // One issue cycle plus 64 waiting cycles
    checkOutput("to_read_en_cycles", rdWidths[0], TIMEOUT + 1);
    checkOutput("step4_rd_count", rd_count, 8);

    // Mem busy holds off a queued write until it drops
    $display("[TB] step 5: busy stall");
    busy = 1'b1;
    applyStimulus(1'b1, 8'd2, 6'd5, 17'd77);
    nBefore = reqStarts.size();
    repeat (8) @(negedge clock);
    checkOutput("busy_no_issue", reqStarts.size() - nBefore, 0);
    checkOutput("busy_not_idle", idle, 0);
    busy = 1'b0;
    fallCyc = cyc;
    repeat (2) @(negedge clock);
    checkOutput("busy_issue_cycle", reqStarts[$], fallCyc + 1);
    waitIdle("step5");
    checkOutput("step5_wr_count", wr_count, 3);
    checkOutput("step5_mem_data", memModel[{8'd2, 6'd5}], 77);
    checkOutput("never_both_en", bothViol, 0);
    checkOutput("final_ack_readen", ackViol, 0);

    // Reset while waiting on a read
    $display("[TB] step 6: reset during read wait");
    applyStimulus(1'b0, 8'd1, 6'd34, 17'd0);
    repeat (6) @(negedge clock);
    checkOutput("pre_rst_read_en", read_en, 1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_read_en", read_en, 0);
    checkOutput("mid_rst_idle", idle, 1);
    checkOutput("mid_rst_cmd_ready", cmd_ready, 1);
    checkOutput("mid_rst_rd_count", rd_count, 0);
    checkOutput("mid_rst_wr_count", wr_count, 0);
    checkOutput("mid_rst_rsp_valid", rsp_valid, 0);
    @(negedge clock);
    reset_n = 1'b1;
    rspBase = rspSeen;
    repeat (80) @(negedge clock);
    checkOutput("post_rst_no_rsp", rspSeen - rspBase, 0);
    checkOutput("post_rst_idle", idle, 1);
    checkOutput("post_rst_read_en", read_en, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
